data_mem_bridge: RTL

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/ppc_types.sv | 17 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/data_mem_bridge.sv | 90 +++++++++
 3 files changed

// File: rtl/ppc_types.sv
// ppc_types: shared load/store bridge constants, default response layout and byte-lane helper.
package ppc_types;
  localparam int BYTE_LANES = 4;
  localparam int DEFAULT_RS_ID_WIDTH = 5;
  typedef struct packed {
    logic [DEFAULT_RS_ID_WIDTH-1:0] rs_id;
    logic [4:0] reg_addr;
    logic [31:0] data;
  } mem_response_t;
  // Lane 0 is the lowest byte address, i.e. the most significant byte of the word.
  function automatic logic [31:0] lane_mask(input logic [BYTE_LANES-1:0] en);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < BYTE_LANES; i++) m[31-8*i -: 8] = {8{en[i]}};
    return m;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with power-of-two depth; push and pop may coincide at any fill level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: load/store unit to synchronous SRAM bridge with an in-order load response queue.
module data_mem_bridge
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   to_mem_valid,
  output logic                   to_mem_ready,
  input  logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
  input  logic [4:0]             to_mem_reg_addr,
  input  logic [31:0]            mem_address,
  input  logic [31:0]            mem_write_data,
  input  logic [BYTE_LANES-1:0]  mem_write_en,
  input  logic [BYTE_LANES-1:0]  mem_read_en,
  output logic                   from_mem_valid,
  input  logic                   from_mem_ready,
  output logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
  output logic [4:0]             from_mem_reg_addr,
  output logic [31:0]            mem_read_data,
  output logic                   sram_en,
  output logic [BYTE_LANES-1:0]  sram_we,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata,
  output logic                   protocol_error
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  // Same layout as mem_response_t, with the tag width taken from this instance.
  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0] reg_addr;
    logic [31:0] data;
  } resp_t;
  resp_t push_data, head;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, accept, is_store, is_load, pop;
  logic pend_q, pend_d, err_q, err_d;
  logic [RS_ID_WIDTH-1:0] pend_rs_q;
  logic [4:0] pend_reg_q;
  logic [BYTE_LANES-1:0] pend_mask_q;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};
  // An in-flight read still needs a FIFO slot, so it counts against capacity.
  assign to_mem_ready = ~rst & ~fifo_full & (fifo_count + CW'(pend_q) < CW'(RESP_DEPTH));
  assign from_mem_valid = ~rst & ~fifo_empty;
  assign from_mem_rs_id = head.rs_id;
  assign from_mem_reg_addr = head.reg_addr;
  assign mem_read_data = head.data;
  assign protocol_error = ~rst & err_q;
  always_comb begin
    is_store = |mem_write_en;
    is_load = ~is_store & |mem_read_en;
    accept = to_mem_valid & to_mem_ready;
    pend_d = accept & is_load;
    err_d = err_q | (accept & (is_store ? |mem_read_en : ~is_load));
    sram_en = accept & (is_store | is_load);
    sram_we = (accept & is_store) ? mem_write_en : '0;
    sram_addr = mem_address[ADDR_WIDTH+1:2];
    sram_wdata = mem_write_data;
    push_data = '{rs_id: pend_rs_q, reg_addr: pend_reg_q, data: sram_rdata & lane_mask(pend_mask_q)};
    pop = from_mem_valid & from_mem_ready;
  end
  always_ff @(posedge clk) begin
    pend_rs_q <= to_mem_rs_id;
    pend_reg_q <= to_mem_reg_addr;
    pend_mask_q <= mem_read_en;
    if (rst) begin
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  sync_fifo #(.WIDTH($bits(resp_t)), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pend_q),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
endmodule
